multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1, meaning: 1 = memory states wait on mem_ready, 0 = memory always ready in one cycle.
REQ-002 Parameter WAIT_LIMIT, default 16, meaning: max consecutive stall cycles before fault, 0 = no timeout; counter width = clog2(WAIT_LIMIT+1), min 1.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 op  input  7  instruction opcode from instruction register.
REQ-006 funct3  input  3  instruction funct3.
REQ-007 funct7b5  input  1  instruction bit 30.
REQ-008 zero / lt / ltu  input  1 each  ALU flags: equal, signed less-than, unsigned less-than.
REQ-009 mem_ready  input  1  memory completes the current access this cycle.
REQ-010 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables/selects.
REQ-011 ResultSrc 2, ALUSrcA 2, ALUSrcB 2, ImmSrc 3, ALUControl 4  output  datapath selects.
REQ-012 instr_done  output  1  one-cycle pulse per retired instruction; fault  output  1  sticky error flag.
REQ-013 state  output  4  current FSM state, debug only.

Function
REQ-014 FSM states, encoded 0-11: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BRANCH, FAULT; all unlisted outputs are 0 in every state.
REQ-015 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00; IRWrite=PCWrite=1 only in the cycle mem_ready=1 (always if MEM_HANDSHAKE=0), which also moves to DECODE; otherwise stay.
REQ-016 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1101111->JAL, 1100011->BRANCH if funct3 not in {010,011}; any other->FAULT.
REQ-017 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; op[5]=0->MEMREAD, op[5]=1->MEMWRITE.
REQ-018 MEMREAD: AdrSrc=1, ResultSrc=00; ->MEMWB on mem_ready, else stay.
REQ-019 MEMWB: ResultSrc=01, RegWrite=1, instr_done=1; ->FETCH.
REQ-020 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready; on mem_ready instr_done=1 and ->FETCH.
REQ-021 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; both ->ALUWB.
REQ-022 ALUWB: ResultSrc=00, RegWrite=1, instr_done=1; ->FETCH.
REQ-023 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; ->ALUWB.
REQ-024 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, instr_done=1; PCWrite=taken; ->FETCH.
REQ-025 taken by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
REQ-026 FAULT: fault=1, all enables 0; exit only by reset.
REQ-027 ImmSrc combinational from op: load/op-imm 000, store 001, branch 010, jal 011, otherwise 000.
REQ-028 ALUControl: ALUOp 00->0000 add, 01->0001 sub, 10 by funct3: 000 sub if op[5]&funct7b5 else add; 001 0110 sll; 010 0101 slt; 011 1001 sltu; 100 0100 xor; 101 1000 sra if funct7b5 else 0111 srl; 110 0011 or; 111 0010 and.
REQ-029 Wait counter: increments each cycle in FETCH/MEMREAD/MEMWRITE with mem_ready=0, clears on any state change or mem_ready=1; if WAIT_LIMIT>0 and it reaches WAIT_LIMIT, next state FAULT, overriding mem_ready low.
REQ-030 mem_ready arriving on the same cycle the counter reaches WAIT_LIMIT: mem_ready wins, normal transition.
REQ-031 Outputs Moore-decoded from state, except PCWrite/IRWrite/MemWrite-completion and instr_done, which may depend on mem_ready/flags in the same cycle.

Reset
REQ-032 reset high asynchronously forces state=FETCH, wait counter=0, fault=0; outputs then take FETCH values.
REQ-033 reset asserted mid-instruction (any state, incl. FAULT) abandons it with no further RegWrite/MemWrite; first post-reset edge evaluates FETCH.

Verification
REQ-034 add (op 0110011, funct3 000, funct7b5 0), mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB; ALUControl 0000 in EXECR; one RegWrite and instr_done pulse; 4 cycles.
REQ-035 lw with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, RegWrite only in MEMWB, total 8 cycles.
REQ-036 bne, zero=0 -> PCWrite=1 in BRANCH; zero=1 -> PCWrite=0; blt with lt=1 -> taken; funct3 010 -> FAULT.
REQ-037 WAIT_LIMIT=4, mem_ready held 0 in FETCH -> FAULT after 4 stall cycles, fault=1 until reset; mem_ready=1 on 4th cycle -> DECODE, no fault.
REQ-038 illegal op 1111111 -> FAULT from DECODE; reset pulse mid-MEMWRITE -> MemWrite drops immediately, state=FETCH.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The controller uses the master view; the datapath (or a bench) uses the slave view.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       instr_done;
    logic       fault;
    logic [3:0] state;

    modport master (
        input  op, funct3, funct7b5, zero, lt, ltu, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
               instr_done, fault, state
    );

    modport slave (
        output op, funct3, funct7b5, zero, lt, ltu, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
               instr_done, fault, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset controller: main FSM with memory handshake, stall
// timeout into a sticky FAULT state, and ALU/immediate decode.
module multicycle_controller #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int WAIT_LIMIT    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_FAULT    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int            CW           = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam int            LIM_M1_I     = (WAIT_LIMIT > 0) ? (WAIT_LIMIT - 1) : 0;
    localparam logic [CW-1:0] LIMIT_M1     = LIM_M1_I[CW-1:0];
    localparam logic          TIMEOUT_EN   = (WAIT_LIMIT > 0);
    localparam logic          HANDSHAKE_EN = (MEM_HANDSHAKE != 0);

    function automatic logic branch_taken(
        input logic [2:0] f3,
        input logic       z,
        input logic       lt_f,
        input logic       ltu_f
    );
        logic taken;
        case (f3)
            3'b000:  taken = z;
            3'b001:  taken = ~z;
            3'b100:  taken = lt_f;
            3'b101:  taken = ~lt_f;
            3'b110:  taken = ltu_f;
            3'b111:  taken = ~ltu_f;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    function automatic logic [3:0] alu_decode(
        input logic [1:0] alu_op,
        input logic [2:0] f3,
        input logic       op5,
        input logic       f7b5
    );
        logic [3:0] ctrl;
        case (alu_op)
            2'b00: ctrl = 4'b0000;
            2'b01: ctrl = 4'b0001;
            2'b10: begin
                case (f3)
                    3'b000:  ctrl = (op5 & f7b5) ? 4'b0001 : 4'b0000;
                    3'b001:  ctrl = 4'b0110;
                    3'b010:  ctrl = 4'b0101;
                    3'b011:  ctrl = 4'b1001;
                    3'b100:  ctrl = 4'b0100;
                    3'b101:  ctrl = f7b5 ? 4'b1000 : 4'b0111;
                    3'b110:  ctrl = 4'b0011;
                    3'b111:  ctrl = 4'b0010;
                    default: ctrl = 4'b0000;
                endcase
            end
            default: ctrl = 4'b0000;
        endcase
        return ctrl;
    endfunction

    function automatic logic [2:0] imm_decode(input logic [6:0] opc);
        logic [2:0] imm;
        case (opc)
            OP_LOAD:   imm = 3'b000;
            OP_ITYPE:  imm = 3'b000;
            OP_STORE:  imm = 3'b001;
            OP_BRANCH: imm = 3'b010;
            OP_JAL:    imm = 3'b011;
            default:   imm = 3'b000;
        endcase
        return imm;
    endfunction

    state_t        state_r;
    state_t        state_next_s;
    state_t        next_base_s;
    logic [CW-1:0] wait_cnt_r;
    logic          fault_r;
    logic          mem_ok_s;
    logic          stall_s;
    logic          stall_hold_s;
    logic          timeout_s;
    logic [1:0]    alu_op_s;

    logic          pc_write_s;
    logic          adr_src_s;
    logic          mem_write_s;
    logic          ir_write_s;
    logic          reg_write_s;
    logic [1:0]    result_src_s;
    logic [1:0]    alu_src_a_s;
    logic [1:0]    alu_src_b_s;
    logic          instr_done_s;

    // Without a handshake the memory is treated as completing every access at once.
    assign mem_ok_s  = HANDSHAKE_EN ? bus.mem_ready : 1'b1;
    assign timeout_s = TIMEOUT_EN && (wait_cnt_r == LIMIT_M1);

    // Next-state and Moore/handshake output decode.
    always_comb begin
        next_base_s  = state_r;
        stall_s      = 1'b0;
        alu_op_s     = 2'b00;
        pc_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        instr_done_s = 1'b0;

        case (state_r)
            S_FETCH: begin
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                if (mem_ok_s) begin
                    ir_write_s  = 1'b1;
                    pc_write_s  = 1'b1;
                    next_base_s = S_DECODE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: next_base_s = S_MEMADR;
                    OP_RTYPE:          next_base_s = S_EXECR;
                    OP_ITYPE:          next_base_s = S_EXECI;
                    OP_JAL:            next_base_s = S_JAL;
                    OP_BRANCH: begin
                        if ((bus.funct3 == 3'b010) || (bus.funct3 == 3'b011)) begin
                            next_base_s = S_FAULT;
                        end else begin
                            next_base_s = S_BRANCH;
                        end
                    end
                    default:           next_base_s = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                next_base_s = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
                if (mem_ok_s) begin
                    next_base_s = S_MEMWB;
                end else begin
                    stall_s = 1'b1;
                end
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                next_base_s  = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                if (mem_ok_s) begin
                    instr_done_s = 1'b1;
                    next_base_s  = S_FETCH;
                end else begin
                    stall_s = 1'b1;
                end
            end
            S_EXECR: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b10;
                next_base_s = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = 2'b10;
                next_base_s = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                next_base_s  = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_write_s  = 1'b1;
                next_base_s = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a_s  = 2'b10;
                alu_op_s     = 2'b01;
                instr_done_s = 1'b1;
                pc_write_s   = branch_taken(bus.funct3, bus.zero, bus.lt, bus.ltu);
                next_base_s  = S_FETCH;
            end
            S_FAULT: begin
                next_base_s = S_FAULT;
            end
            default: begin
                next_base_s = S_FAULT;
            end
        endcase

        // A stall that has used up its budget diverts to FAULT; a completing access never does.
        state_next_s = (stall_s && timeout_s) ? S_FAULT : next_base_s;
        stall_hold_s = stall_s && (state_next_s == state_r);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Consecutive stall counter; saturates so a disabled timeout cannot wrap it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= '0;
        end else if (!stall_hold_s) begin
            wait_cnt_r <= '0;
        end else if (!(&wait_cnt_r)) begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Sticky fault flag, raised together with entry into FAULT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= fault_r | (state_next_s == S_FAULT);
        end
    end

    assign bus.PCWrite    = pc_write_s;
    assign bus.AdrSrc     = adr_src_s;
    assign bus.MemWrite   = mem_write_s;
    assign bus.IRWrite    = ir_write_s;
    assign bus.RegWrite   = reg_write_s;
    assign bus.ResultSrc  = result_src_s;
    assign bus.ALUSrcA    = alu_src_a_s;
    assign bus.ALUSrcB    = alu_src_b_s;
    assign bus.ImmSrc     = imm_decode(bus.op);
    assign bus.ALUControl = alu_decode(alu_op_s, bus.funct3, bus.op[5], bus.funct7b5);
    assign bus.instr_done = instr_done_s;
    assign bus.fault      = fault_r;
    assign bus.state      = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected-vector tables
// for each instruction class, plus reset and stall-timeout scenarios.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multicycle_controller_if b ();
    multicycle_controller_if b4 ();

    multicycle_controller #(.MEM_HANDSHAKE(1), .WAIT_LIMIT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b.master)
    );

    multicycle_controller #(.MEM_HANDSHAKE(1), .WAIT_LIMIT(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4.master)
    );

    int checks_cnt = 0;
    int fail_cnt   = 0;

    // Expected-vector layout: {state, IRWrite, PCWrite, RegWrite, MemWrite, instr_done, fault, ALUControl}
    logic        row_mr  [32];
    logic [13:0] row_exp [32];
    int          nrows = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add_row(input logic mr, input logic [3:0] st, input logic [5:0] fl, input logic [3:0] ac);
        row_mr[nrows]  = mr;
        row_exp[nrows] = {st, fl, ac};
        nrows++;
    endtask

    function automatic logic [13:0] obs_vec();
        return {b.state, b.IRWrite, b.PCWrite, b.RegWrite, b.MemWrite,
                b.instr_done, b.fault, b.ALUControl};
    endfunction

    task automatic run_seq(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic f7);
        b.op       = op;
        b.funct3   = f3;
        b.funct7b5 = f7;
        for (int i = 0; i < nrows; i++) begin
            @(negedge clk);
            b.mem_ready = row_mr[i];
            #1;
            check_eq($sformatf("%s_c%0d", tag, i), {18'd0, obs_vec()}, {18'd0, row_exp[i]});
        end
        nrows = 0;
    endtask

    task automatic alu_seq(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [3:0] exec_st, input logic [3:0] aluc);
        add_row(1'b1, 4'd0, 6'b110000, 4'b0000);
        add_row(1'b1, 4'd1, 6'b000000, 4'b0000);
        add_row(1'b1, exec_st, 6'b000000, aluc);
        add_row(1'b1, 4'd8, 6'b001010, 4'b0000);
        run_seq(tag, op, f3, f7);
    endtask

    task automatic branch_seq(input string tag, input logic [2:0] f3, input logic [5:0] fl);
        add_row(1'b1, 4'd0, 6'b110000, 4'b0000);
        add_row(1'b1, 4'd1, 6'b000000, 4'b0000);
        add_row(1'b1, 4'd10, fl, 4'b0001);
        run_seq(tag, 7'b1100011, f3, 1'b0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq({tag, "_state"}, {28'd0, b.state}, 32'd0);
        check_eq({tag, "_fault"}, {31'd0, b.fault}, 32'd0);
        @(negedge clk);
        b.mem_ready = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        b.op        = 7'd0;
        b.funct3    = 3'd0;
        b.funct7b5  = 1'b0;
        b.zero      = 1'b0;
        b.lt        = 1'b0;
        b.ltu       = 1'b0;
        b.mem_ready = 1'b0;
        b4.op       = 7'd0;
        b4.funct3   = 3'd0;
        b4.funct7b5 = 1'b0;
        b4.zero     = 1'b0;
        b4.lt       = 1'b0;
        b4.ltu      = 1'b0;
        b4.mem_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_state",   {28'd0, b.state},     32'd0);
        check_eq("rst_alusrcb", {30'd0, b.ALUSrcB},   32'd2);
        check_eq("rst_ressrc",  {30'd0, b.ResultSrc}, 32'd2);
        check_eq("rst_pcwrite", {31'd0, b.PCWrite},   32'd0);
        check_eq("rst_fault",   {31'd0, b.fault},     32'd0);
        reset = 1'b0;

        // R/I-type ALU instructions
        alu_seq("add",    7'b0110011, 3'b000, 1'b0, 4'd6, 4'b0000);
        alu_seq("sub",    7'b0110011, 3'b000, 1'b1, 4'd6, 4'b0001);
        alu_seq("addi7",  7'b0010011, 3'b000, 1'b1, 4'd7, 4'b0000);
        alu_seq("srai",   7'b0010011, 3'b101, 1'b1, 4'd7, 4'b1000);
        alu_seq("srl",    7'b0110011, 3'b101, 1'b0, 4'd6, 4'b0111);
        alu_seq("sltu",   7'b0110011, 3'b011, 1'b0, 4'd6, 4'b1001);
        alu_seq("and",    7'b0110011, 3'b111, 1'b0, 4'd6, 4'b0010);

        // lw with three stall cycles in MEMREAD: 8 cycles total
        add_row(1'b1, 4'd0, 6'b110000, 4'b0000);
        add_row(1'b1, 4'd1, 6'b000000, 4'b0000);
        add_row(1'b1, 4'd2, 6'b000000, 4'b0000);
        add_row(1'b0, 4'd3, 6'b000000, 4'b0000);
        add_row(1'b0, 4'd3, 6'b000000, 4'b0000);
        add_row(1'b0, 4'd3, 6'b000000, 4'b0000);
        add_row(1'b1, 4'd3, 6'b000000, 4'b0000);
        add_row(1'b1, 4'd4, 6'b001010, 4'b0000);
        run_seq("lw", 7'b0000011, 3'b010, 1'b0);

        // sw with one stall in MEMWRITE
        add_row(1'b1, 4'd0, 6'b110000, 4'b0000);
        add_row(1'b1, 4'd1, 6'b000000, 4'b0000);
        add_row(1'b1, 4'd2, 6'b000000, 4'b0000);
        add_row(1'b0, 4'd5, 6'b000100, 4'b0000);
        add_row(1'b1, 4'd5, 6'b000110, 4'b0000);
        run_seq("sw", 7'b0100011, 3'b010, 1'b0);

        // Branches
        b.zero = 1'b0;
        branch_seq("bne_nz", 3'b001, 6'b010010);
        b.zero = 1'b1;
        branch_seq("bne_z", 3'b001, 6'b000010);
        b.lt = 1'b1;
        branch_seq("blt_t", 3'b100, 6'b010010);
        b.ltu = 1'b1;
        branch_seq("bgeu_nt", 3'b111, 6'b000010);
        branch_seq("beq_t", 3'b000, 6'b010010);

        // jal
        add_row(1'b1, 4'd0, 6'b110000, 4'b0000);
        add_row(1'b1, 4'd1, 6'b000000, 4'b0000);
        add_row(1'b1, 4'd9, 6'b010000, 4'b0000);
        add_row(1'b1, 4'd8, 6'b001010, 4'b0000);
        run_seq("jal", 7'b1101111, 3'b000, 1'b0);

        // Branch with funct3 010 faults and stays faulted
        add_row(1'b1, 4'd0,  6'b110000, 4'b0000);
        add_row(1'b1, 4'd1,  6'b000000, 4'b0000);
        add_row(1'b1, 4'd11, 6'b000001, 4'b0000);
        add_row(1'b1, 4'd11, 6'b000001, 4'b0000);
        add_row(1'b1, 4'd11, 6'b000001, 4'b0000);
        run_seq("br010", 7'b1100011, 3'b010, 1'b0);

        // Immediate select decode (state held in FAULT)
        b.op = 7'b0000011; #1; check_eq("imm_load",  {29'd0, b.ImmSrc}, 32'd0);
        b.op = 7'b0100011; #1; check_eq("imm_store", {29'd0, b.ImmSrc}, 32'd1);
        b.op = 7'b1100011; #1; check_eq("imm_br",    {29'd0, b.ImmSrc}, 32'd2);
        b.op = 7'b1101111; #1; check_eq("imm_jal",   {29'd0, b.ImmSrc}, 32'd3);

        pulse_reset("rst1");

        // Illegal opcode
        add_row(1'b1, 4'd0,  6'b110000, 4'b0000);
        add_row(1'b1, 4'd1,  6'b000000, 4'b0000);
        add_row(1'b1, 4'd11, 6'b000001, 4'b0000);
        run_seq("illop", 7'b1111111, 3'b000, 1'b0);

        pulse_reset("rst2");

        // Reset asserted while MemWrite is held
        add_row(1'b1, 4'd0, 6'b110000, 4'b0000);
        add_row(1'b1, 4'd1, 6'b000000, 4'b0000);
        add_row(1'b1, 4'd2, 6'b000000, 4'b0000);
        add_row(1'b0, 4'd5, 6'b000100, 4'b0000);
        run_seq("swrst", 7'b0100011, 3'b010, 1'b0);
        reset = 1'b1;
        #1;
        check_eq("swrst_memwrite", {31'd0, b.MemWrite}, 32'd0);
        check_eq("swrst_state",    {28'd0, b.state},    32'd0);
        b.mem_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_eq("swrst_post", {28'd0, b.state}, 32'd1);

        // Stall timeout with WAIT_LIMIT=4
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        b4.mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("wl_c0", {28'd0, b4.state}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            check_eq($sformatf("wl_c%0d", k), {28'd0, b4.state}, 32'd0);
        end
        @(negedge clk);
        #1;
        check_eq("wl_fault_st", {28'd0, b4.state}, 32'd11);
        check_eq("wl_fault",    {31'd0, b4.fault}, 32'd1);
        b4.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("wl_sticky_st", {28'd0, b4.state}, 32'd11);
        check_eq("wl_sticky",    {31'd0, b4.fault}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("wl_rst_fault", {31'd0, b4.fault}, 32'd0);
        @(negedge clk);
        b4.mem_ready = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        b4.mem_ready = 1'b1;
        #1;
        check_eq("wl_last_st", {28'd0, b4.state}, 32'd0);
        @(negedge clk);
        #1;
        check_eq("wl_ready_st",    {28'd0, b4.state}, 32'd1);
        check_eq("wl_ready_fault", {31'd0, b4.fault}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
